ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Owns the shared ODE solver RAM (one write port, two read ports) and time-multiplexes it between two requesters: the IO module (packet loading, result read-out) and the solver core (integration steps). It sits between both masters and the RAM instance inside the chip top level, replacing the direct IO-to-RAM wiring. Ownership changes through a registered request/grant handshake with round-robin tie-break and an optional burst limit.

## Interface

- RAM_ADDRESS_WIDTH, 13, RAM address width
- DATA_WIDTH, 64, RAM word width
- MAX_BURST, 64, maximum consecutive granted cycles when the burst limit is compiled in (>=2)
- CLK  input  1  single clock, all logic on rising edge
- RST  input  1  synchronous, active-low reset
- IO_Req / Core_Req  input  1  requester wants the RAM
- IO_Gnt / Core_Gnt  output  1  registered grant, at most one high
- IO_WR_Enable / Core_WR_Enable  input  1  write strobe
- IO_WR_Address / Core_WR_Address  input  RAM_ADDRESS_WIDTH  write address
- IO_WR_Data / Core_WR_Data  input  DATA_WIDTH  write data
- IO_RD_Enable / Core_RD_Enable  input  1  read strobe, both read ports
- IO_RD1_Address, IO_RD2_Address / Core_RD1_Address, Core_RD2_Address  input  RAM_ADDRESS_WIDTH  read addresses
- IO_RD_Valid / Core_RD_Valid  output  1  read data valid for that requester
- RD1_Data / RD2_Data  output  DATA_WIDTH  RAM read data, broadcast to both requesters
- RAM_WR_Enable  output  1; RAM_WR_Address, RAM_RD1_Address, RAM_RD2_Address  output  RAM_ADDRESS_WIDTH; RAM_WR_Data  output  DATA_WIDTH  to RAM
- RAM_RD1_Data / RAM_RD2_Data  input  DATA_WIDTH  from RAM

## Operation

- States: IDLE, IO_OWN, CORE_OWN. Last-owner flag (1 bit) and burst counter (ceil(log2(MAX_BURST)) bits).
- IDLE: only IO_Req -> IO_OWN; only Core_Req -> CORE_OWN; both -> the requester that is not the last owner; neither -> stay.
- X_OWN: X_Req low -> IDLE, last owner = X. X_Req high -> stay (unless the burst limit fires, see Configuration).
- Gnt outputs are decoded from the registered state: IO_Gnt = (state==IO_OWN), Core_Gnt = (state==CORE_OWN).
- RAM address/data muxes select the owner's inputs; in IDLE they select the IO inputs. RAM_WR_Enable = owner WR_Enable AND owner Gnt; 0 in IDLE. Non-owner strobes are ignored, never queued.
- Read: RAM read is registered (data one cycle after address). X_RD_Valid <= X_RD_Enable AND X_Gnt; RD1/RD2_Data pass RAM_RD1/RD2_Data through unregistered.
- Reset (RST=0 at an edge): state IDLE, last owner = Core (IO wins the first tie), counter 0, both Gnt 0, both RD_Valid 0. RAM_WR_Enable is 0 while RST is low regardless of state. Reset mid-burst drops the grant with no partial-cycle write.

## Timing

- Grant latency: Req sampled high in IDLE at edge n -> Gnt high after edge n+1 (one cycle).
- Release: Req sampled low at edge m -> Gnt low after m; the next owner's Gnt rises one cycle later, giving one mandatory idle cycle between owners.
- A write commits at the edge where WR_Enable and Gnt are both high. Requesters must sample Gnt combinationally each cycle.
- Read valid: RD_Enable at edge k with Gnt -> RD_Valid high and data valid in cycle k+1, even if Gnt has dropped at k+1 (last read before release still returns).
- Both Req asserted in the same IDLE cycle: exactly one grant, chosen by the round-robin rule.

## Configuration

- ARB_BURST_LIMIT_EN defined: the counter increments every owned cycle and clears in IDLE. When it equals MAX_BURST-1 and the other Req is high, the next state is IDLE and last owner = current owner, so the other requester wins. The preempted requester keeps Req high and is re-granted later. If the other Req is low, the counter saturates and ownership continues.
- Not defined: no counter logic; the owner holds the RAM until it drops Req.

## Test plan

- Reset: RST=0 for 3 cycles with IO_Req=1 and IO_WR_Enable=1 -> both Gnt=0, RAM_WR_Enable=0, RD_Valid=0. After RST=1, IO_Gnt rises one cycle later.
- IO writes addr 0x005 = 0x0123456789ABCDEF, then RD_Enable with RD1=0x005 -> IO_RD_Valid=1 and RD1_Data=0x0123456789ABCDEF the next cycle. Core_RD_Valid stays 0.
- Simultaneous IO_Req and Core_Req from reset -> IO granted. IO releases -> one idle cycle, then Core_Gnt. Both released and re-requested together -> IO granted (round-robin).
- Core_WR_Enable=1 to addr 0x010 while IO owns -> no RAM write; a subsequent read of 0x010 returns its prior value.
- With ARB_BURST_LIMIT_EN and MAX_BURST=4: IO holds Req, Core_Req asserted -> IO_Gnt high for exactly 4 cycles, 1 idle cycle, then Core_Gnt. Without the macro, IO_Gnt stays high until IO_Req drops.
- RST=0 asserted during a Core write burst -> Core_Gnt low next cycle and no write at the reset edge.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// Bus bundle for ram_access_arbiter: both requester ports plus the RAM port.
// Modports: slave = arbiter side, master = requesters/RAM environment side.
interface ram_access_arbiter_if #(
    parameter int RAM_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH        = 64
);
    // IO requester
    logic                         IO_Req;
    logic                         IO_Gnt;
    logic                         IO_WR_Enable;
    logic [RAM_ADDRESS_WIDTH-1:0] IO_WR_Address;
    logic [DATA_WIDTH-1:0]        IO_WR_Data;
    logic                         IO_RD_Enable;
    logic [RAM_ADDRESS_WIDTH-1:0] IO_RD1_Address;
    logic [RAM_ADDRESS_WIDTH-1:0] IO_RD2_Address;
    logic                         IO_RD_Valid;

    // Solver core requester
    logic                         Core_Req;
    logic                         Core_Gnt;
    logic                         Core_WR_Enable;
    logic [RAM_ADDRESS_WIDTH-1:0] Core_WR_Address;
    logic [DATA_WIDTH-1:0]        Core_WR_Data;
    logic                         Core_RD_Enable;
    logic [RAM_ADDRESS_WIDTH-1:0] Core_RD1_Address;
    logic [RAM_ADDRESS_WIDTH-1:0] Core_RD2_Address;
    logic                         Core_RD_Valid;

    // Read data broadcast to both requesters
    logic [DATA_WIDTH-1:0]        RD1_Data;
    logic [DATA_WIDTH-1:0]        RD2_Data;

    // RAM side
    logic                         RAM_WR_Enable;
    logic [RAM_ADDRESS_WIDTH-1:0] RAM_WR_Address;
    logic [DATA_WIDTH-1:0]        RAM_WR_Data;
    logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD1_Address;
    logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD2_Address;
    logic [DATA_WIDTH-1:0]        RAM_RD1_Data;
    logic [DATA_WIDTH-1:0]        RAM_RD2_Data;

    modport slave (
        input  IO_Req, IO_WR_Enable, IO_WR_Address, IO_WR_Data,
        input  IO_RD_Enable, IO_RD1_Address, IO_RD2_Address,
        output IO_Gnt, IO_RD_Valid,
        input  Core_Req, Core_WR_Enable, Core_WR_Address, Core_WR_Data,
        input  Core_RD_Enable, Core_RD1_Address, Core_RD2_Address,
        output Core_Gnt, Core_RD_Valid,
        output RD1_Data, RD2_Data,
        output RAM_WR_Enable, RAM_WR_Address, RAM_WR_Data,
        output RAM_RD1_Address, RAM_RD2_Address,
        input  RAM_RD1_Data, RAM_RD2_Data
    );

    modport master (
        output IO_Req, IO_WR_Enable, IO_WR_Address, IO_WR_Data,
        output IO_RD_Enable, IO_RD1_Address, IO_RD2_Address,
        input  IO_Gnt, IO_RD_Valid,
        output Core_Req, Core_WR_Enable, Core_WR_Address, Core_WR_Data,
        output Core_RD_Enable, Core_RD1_Address, Core_RD2_Address,
        input  Core_Gnt, Core_RD_Valid,
        input  RD1_Data, RD2_Data,
        input  RAM_WR_Enable, RAM_WR_Address, RAM_WR_Data,
        input  RAM_RD1_Address, RAM_RD2_Address,
        output RAM_RD1_Data, RAM_RD2_Data
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Time-multiplexes the shared solver RAM between the IO module and the core
// using a registered request/grant handshake with round-robin tie-break.
// Ports: CLK, RST (sync, active-low), bus (ram_access_arbiter_if.slave).
// Optional macro ARB_BURST_LIMIT_EN: owner is preempted after MAX_BURST
// granted cycles when the other requester is waiting.
module ram_access_arbiter #(
    parameter int MAX_BURST = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    ram_access_arbiter_if.slave  bus
);

    if (MAX_BURST < 2) begin : g_max_burst_chk
        $error("MAX_BURST must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IO_OWN   = 2'd1,
        CORE_OWN = 2'd2
    } state_e;

    state_e state_q, state_d;
    // 1 = core was the last owner, so IO wins the next tie
    logic   last_core_q, last_core_d;
    logic   io_rd_valid_q, io_rd_valid_d;
    logic   core_rd_valid_q, core_rd_valid_d;
    logic   io_gnt, core_gnt;
    logic   burst_done;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts owned cycles; saturates so an uncontested owner keeps the RAM.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign burst_done = (cnt_q == CNT_LAST);
`else
    assign burst_done = 1'b0;
`endif

    assign io_gnt   = (state_q == IO_OWN);
    assign core_gnt = (state_q == CORE_OWN);

    always_comb begin
        state_d     = state_q;
        last_core_d = last_core_q;
        unique case (state_q)
            IDLE: begin
                if (bus.IO_Req && (!bus.Core_Req || last_core_q)) begin
                    state_d = IO_OWN;
                end else if (bus.Core_Req) begin
                    state_d = CORE_OWN;
                end
            end
            IO_OWN: begin
                if (!bus.IO_Req || (burst_done && bus.Core_Req)) begin
                    state_d     = IDLE;
                    last_core_d = 1'b0;
                end
            end
            CORE_OWN: begin
                if (!bus.Core_Req || (burst_done && bus.IO_Req)) begin
                    state_d     = IDLE;
                    last_core_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        io_rd_valid_d   = bus.IO_RD_Enable & io_gnt;
        core_rd_valid_d = bus.Core_RD_Enable & core_gnt;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q         <= IDLE;
            last_core_q     <= 1'b1;
            io_rd_valid_q   <= 1'b0;
            core_rd_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_core_q     <= last_core_d;
            io_rd_valid_q   <= io_rd_valid_d;
            core_rd_valid_q <= core_rd_valid_d;
        end
    end

    // RAM muxes default to the IO inputs whenever the core is not the owner.
    always_comb begin
        bus.IO_Gnt        = io_gnt;
        bus.Core_Gnt      = core_gnt;
        bus.IO_RD_Valid   = io_rd_valid_q;
        bus.Core_RD_Valid = core_rd_valid_q;
        bus.RD1_Data      = bus.RAM_RD1_Data;
        bus.RD2_Data      = bus.RAM_RD2_Data;
        if (core_gnt) begin
            bus.RAM_WR_Address  = bus.Core_WR_Address;
            bus.RAM_WR_Data     = bus.Core_WR_Data;
            bus.RAM_RD1_Address = bus.Core_RD1_Address;
            bus.RAM_RD2_Address = bus.Core_RD2_Address;
        end else begin
            bus.RAM_WR_Address  = bus.IO_WR_Address;
            bus.RAM_WR_Data     = bus.IO_WR_Data;
            bus.RAM_RD1_Address = bus.IO_RD1_Address;
            bus.RAM_RD2_Address = bus.IO_RD2_Address;
        end
        // Gated by RST so a reset edge mid-burst never commits a write.
        bus.RAM_WR_Enable = RST &
            ((io_gnt & bus.IO_WR_Enable) | (core_gnt & bus.Core_WR_Enable));
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized self-checking bench for ram_access_arbiter with a
// behavioural ownership/memory reference model and a registered-read RAM.
module tb_ram_access_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 64;
    localparam int MAXB = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    ram_access_arbiter_if #(.RAM_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_access_arbiter #(.MAX_BURST(MAXB)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read (read-before-write)
    logic [DW-1:0] ram [0:31];
    always @(posedge clk) begin
        if (bus.RAM_WR_Enable) ram[bus.RAM_WR_Address[4:0]] <= bus.RAM_WR_Data;
        bus.RAM_RD1_Data <= ram[bus.RAM_RD1_Address[4:0]];
        bus.RAM_RD2_Data <= ram[bus.RAM_RD2_Address[4:0]];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: owner 0 = nobody, 1 = IO, 2 = core
    int            owner = 0;
    int            last  = 2;
    int            held  = 0;
    logic          ev_io = 1'b0;
    logic          ev_core = 1'b0;
    logic [DW-1:0] exp_rd1 = '0;
    logic [DW-1:0] exp_rd2 = '0;
    logic [DW-1:0] exp_mem [0:31];

    task automatic model_edge();
        logic mine, other;
        if (!rst) begin
            owner = 0; last = 2; held = 0;
            ev_io = 1'b0; ev_core = 1'b0;
            return;
        end
        ev_io   = (owner == 1) && bus.IO_RD_Enable;
        ev_core = (owner == 2) && bus.Core_RD_Enable;
        if (owner == 2) begin
            exp_rd1 = exp_mem[bus.Core_RD1_Address[4:0]];
            exp_rd2 = exp_mem[bus.Core_RD2_Address[4:0]];
        end else begin
            exp_rd1 = exp_mem[bus.IO_RD1_Address[4:0]];
            exp_rd2 = exp_mem[bus.IO_RD2_Address[4:0]];
        end
        if (owner == 1 && bus.IO_WR_Enable)
            exp_mem[bus.IO_WR_Address[4:0]] = bus.IO_WR_Data;
        if (owner == 2 && bus.Core_WR_Enable)
            exp_mem[bus.Core_WR_Address[4:0]] = bus.Core_WR_Data;
        if (owner == 0) begin
            held = 0;
            if (bus.IO_Req && bus.Core_Req) owner = (last == 1) ? 2 : 1;
            else if (bus.IO_Req) owner = 1;
            else if (bus.Core_Req) owner = 2;
        end else begin
            mine  = (owner == 1) ? bus.IO_Req : bus.Core_Req;
            other = (owner == 1) ? bus.Core_Req : bus.IO_Req;
            held++;
            if (!mine || (BURST_EN && held >= MAXB && other)) begin
                last  = owner;
                owner = 0;
                held  = 0;
            end
        end
    endtask

    task automatic pre_checks();
        logic exp_we;
        exp_we = rst && ((owner == 1 && bus.IO_WR_Enable) ||
                         (owner == 2 && bus.Core_WR_Enable));
        chk("wr_en", bus.RAM_WR_Enable, exp_we);
        if (exp_we) begin
            chk("wr_addr", bus.RAM_WR_Address,
                (owner == 2) ? bus.Core_WR_Address : bus.IO_WR_Address);
            chk("wr_data", bus.RAM_WR_Data,
                (owner == 2) ? bus.Core_WR_Data : bus.IO_WR_Data);
        end
        chk("rd1_addr", bus.RAM_RD1_Address,
            (owner == 2) ? bus.Core_RD1_Address : bus.IO_RD1_Address);
    endtask

    task automatic post_checks();
        chk("io_gnt", bus.IO_Gnt, owner == 1);
        chk("core_gnt", bus.Core_Gnt, owner == 2);
        chk("io_valid", bus.IO_RD_Valid, ev_io);
        chk("core_valid", bus.Core_RD_Valid, ev_core);
        if (ev_io || ev_core) begin
            chk("rd1_data", bus.RD1_Data, exp_rd1);
            chk("rd2_data", bus.RD2_Data, exp_rd2);
        end
    endtask

    task automatic cyc();
        #1;
        pre_checks();
        @(posedge clk);
        model_edge();
        #1;
        post_checks();
    endtask

    task automatic clear_inputs();
        bus.IO_Req = 0; bus.IO_WR_Enable = 0; bus.IO_RD_Enable = 0;
        bus.IO_WR_Address = '0; bus.IO_WR_Data = '0;
        bus.IO_RD1_Address = '0; bus.IO_RD2_Address = '0;
        bus.Core_Req = 0; bus.Core_WR_Enable = 0; bus.Core_RD_Enable = 0;
        bus.Core_WR_Address = '0; bus.Core_WR_Data = '0;
        bus.Core_RD1_Address = '0; bus.Core_RD2_Address = '0;
    endtask

    task automatic do_reset();
        rst = 0;
        cyc();
        rst = 1;
    endtask

    initial begin
        int run;
        bit stopped;
        clear_inputs();

        // Reset held with IO requesting and writing
        rst = 0;
        bus.IO_Req = 1; bus.IO_WR_Enable = 1;
        bus.IO_WR_Address = 13'h005;
        bus.IO_WR_Data = 64'h0123456789ABCDEF;
        repeat (3) begin
            cyc();
            chk("rst_io_gnt", bus.IO_Gnt, 1'b0);
        end
        rst = 1;
        cyc();
        chk("io_gnt_latency", bus.IO_Gnt, 1'b1);
        cyc();
        bus.IO_WR_Enable = 0; bus.IO_RD_Enable = 1;
        bus.IO_RD1_Address = 13'h005; bus.IO_RD2_Address = 13'h005;
        cyc();
        chk("rd_0x005_valid", bus.IO_RD_Valid, 1'b1);
        chk("rd_0x005_data", bus.RD1_Data, 64'h0123456789ABCDEF);
        chk("rd_0x005_core_valid", bus.Core_RD_Valid, 1'b0);
        bus.IO_RD_Enable = 0;

        // Fill the rest of the RAM through IO
        bus.IO_WR_Enable = 1;
        for (int i = 0; i < 32; i++) begin
            if (i == 5) continue;
            bus.IO_WR_Address = AW'(i);
            bus.IO_WR_Data = 64'hA5A5_0000_0000_0000 | 64'(i);
            cyc();
        end
        clear_inputs();
        cyc();

        // Core write while IO owns must be dropped
        bus.IO_Req = 1;
        do_reset();
        cyc();
        bus.Core_Req = 1; bus.Core_WR_Enable = 1;
        bus.Core_WR_Address = 13'h010; bus.Core_WR_Data = 64'hDEAD_BEEF_0000_0010;
        cyc();
        cyc();
        bus.IO_RD_Enable = 1;
        bus.IO_RD1_Address = 13'h010; bus.IO_RD2_Address = 13'h010;
        cyc();
        chk("core_wr_ignored", bus.RD1_Data, 64'hA5A5_0000_0000_0010);
        clear_inputs();

        // Tie from reset, release hand-over, round-robin re-request
        do_reset();
        bus.IO_Req = 1; bus.Core_Req = 1;
        cyc();
        chk("tie_io_first", bus.IO_Gnt, 1'b1);
        bus.IO_Req = 0;
        cyc();
        chk("handover_idle", bus.Core_Gnt, 1'b0);
        cyc();
        chk("handover_core", bus.Core_Gnt, 1'b1);
        bus.Core_Req = 0;
        cyc();
        bus.IO_Req = 1; bus.Core_Req = 1;
        cyc();
        chk("rr_io", bus.IO_Gnt, 1'b1);
        clear_inputs();

        // Burst limit: IO holds Req while core waits
        do_reset();
        bus.IO_Req = 1;
        cyc();
        bus.Core_Req = 1;
        run = bus.IO_Gnt ? 1 : 0;
        stopped = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (!stopped && bus.IO_Gnt) run++;
            else stopped = 1;
        end
        chk("burst_len", 64'(run), BURST_EN ? 64'(MAXB) : 64'd16);
        clear_inputs();

        // Reset during a core write burst
        do_reset();
        bus.Core_Req = 1; bus.Core_WR_Enable = 1;
        for (int i = 0; i < 3; i++) begin
            bus.Core_WR_Address = AW'(i + 8);
            bus.Core_WR_Data = {32'hC0DE0000, 32'(i)};
            cyc();
        end
        rst = 0;
        cyc();
        chk("rst_core_gnt", bus.Core_Gnt, 1'b0);
        rst = 1;
        clear_inputs();
        cyc();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) bus.IO_Req = ~bus.IO_Req;
            if ($urandom_range(0, 7) == 0) bus.Core_Req = ~bus.Core_Req;
            bus.IO_WR_Enable     = 1'($urandom_range(0, 1));
            bus.IO_WR_Address    = AW'($urandom_range(0, 31));
            bus.IO_WR_Data       = {$urandom, $urandom};
            bus.IO_RD_Enable     = 1'($urandom_range(0, 1));
            bus.IO_RD1_Address   = AW'($urandom_range(0, 31));
            bus.IO_RD2_Address   = AW'($urandom_range(0, 31));
            bus.Core_WR_Enable   = 1'($urandom_range(0, 1));
            bus.Core_WR_Address  = AW'($urandom_range(0, 31));
            bus.Core_WR_Data     = {$urandom, $urandom};
            bus.Core_RD_Enable   = 1'($urandom_range(0, 1));
            bus.Core_RD1_Address = AW'($urandom_range(0, 31));
            bus.Core_RD2_Address = AW'($urandom_range(0, 31));
            rst = ($urandom_range(0, 99) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
